// File: rtl/xor_descrambler_rx.sv
// Serial receiver for an x^7+x^4+1 self-synchronizing scrambled bit stream.
// After seven accepted bits the history register matches the transmitter's
// and descrambled bits are packed LSB-first into WIDTH-bit words, which are
// offered on a valid/ready output with a sticky overrun flag for dropped words.
module xor_descrambler_rx #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_valid,
    input  logic             resync,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             locked,
    output logic             overrun
);

    localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_POS = CNT_W'(WIDTH - 1);
    localparam logic [2:0] FILL_LAST = 3'd6;

    typedef enum logic {
        ST_SYNC = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [6:0]         sr_q, sr_d;
    logic [2:0]         fill_q, fill_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0]   word_q, word_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic               out_valid_q, out_valid_d;
    logic               overrun_q, overrun_d;

    logic               accept;
    logic               desc_bit;
    logic               word_done;
    logic [WIDTH-1:0]   done_word;

    // A bit counts only when valid and not swallowed by a resync request.
    always_comb begin
        accept   = in_valid & ~resync;
        desc_bit = in_bit ^ sr_q[6] ^ sr_q[3];
    end

    // History of received (still scrambled) bits, oldest bit at sr[6].
    always_comb begin
        sr_d = sr_q;
        if (accept) begin
            sr_d = {sr_q[5:0], in_bit};
        end
    end

    // SYNC waits for seven bits to fill the history, then RUN decodes.
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        if (resync) begin
            state_d = ST_SYNC;
            fill_d  = 3'd0;
        end else if (accept) begin
            case (state_q)
                ST_SYNC: begin
                    if (fill_q == FILL_LAST) begin
                        state_d = ST_RUN;
                        fill_d  = 3'd0;
                    end else begin
                        fill_d = fill_q + 3'd1;
                    end
                end
                ST_RUN: begin
                    fill_d = 3'd0;
                end
                default: begin
                    state_d = ST_SYNC;
                    fill_d  = 3'd0;
                end
            endcase
        end
    end

    // LSB-first word assembly; done_word carries the finished word for one cycle.
    always_comb begin
        bit_cnt_d = bit_cnt_q;
        word_d    = word_q;
        word_done = 1'b0;
        done_word = word_q;
        if (resync) begin
            bit_cnt_d = '0;
            word_d    = '0;
        end else if (accept && (state_q == ST_RUN)) begin
            done_word[bit_cnt_q] = desc_bit;
            if (bit_cnt_q == LAST_POS) begin
                word_done = 1'b1;
                bit_cnt_d = '0;
                word_d    = '0;
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
                word_d    = done_word;
            end
        end
    end

    // Output holding register: a new word may replace one being consumed this cycle.
    always_comb begin
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q & ~out_ready;
        overrun_d   = overrun_q;
        if (word_done) begin
            if (!out_valid_q || out_ready) begin
                out_data_d  = done_word;
                out_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_SYNC;
            sr_q        <= '0;
            fill_q      <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            overrun_q   <= overrun_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign locked    = (state_q == ST_RUN);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_xor_descrambler_rx.sv
// Directed bench for xor_descrambler_rx. Plaintext words are scrambled by a
// bench-side x^7+x^4+1 scrambler, expected words are queued as they are sent
// and popped when the receiver presents them.
module tb_xor_descrambler_rx;

    localparam int WIDTH = 8;

    logic             clk;
    logic             rst_n;
    logic             in_bit;
    logic             in_valid;
    logic             resync;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic             locked;
    logic             overrun;

    int               errors = 0;
    int               checks = 0;

    logic [6:0]       txh;
    int               syncCnt;
    int               wordPos;
    logic             wordDone;
    logic             autoCheck;
    logic [7:0]       wordBuf;
    logic [7:0]       sbQ[$];
    logic [7:0]       rawPattern;

    xor_descrambler_rx #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_valid  (in_valid),
        .resync    (resync),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .locked    (locked),
        .overrun   (overrun)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Guard against a stuck run.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic popCheck(input string tag);
        logic [7:0] exp;
        if (sbQ.size() == 0) begin
            checks++;
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=none_queued", tag, out_data);
        end else begin
            exp = sbQ.pop_front();
            checkOutput(tag, 16'(out_data), 16'(exp));
        end
    endtask

    task automatic doReset();
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_bit   = 1'b1;
        resync   = 1'b0;
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        txh      = 7'd0;
        syncCnt  = 7;
        wordPos  = 0;
        sbQ.delete();
    endtask

    // Drive one raw line bit for one cycle and advance the bench's view of the link.
    task automatic applyStimulus(input logic rawBit, input logic rs);
        in_bit   = rawBit;
        in_valid = 1'b1;
        resync   = rs;
        @(posedge clk);
        wordDone = 1'b0;
        if (rs) begin
            syncCnt = 7;
            wordPos = 0;
        end else begin
            txh = {txh[5:0], rawBit};
            if (syncCnt > 0) begin
                syncCnt--;
            end else begin
                wordPos++;
                if (wordPos == WIDTH) begin
                    wordPos  = 0;
                    wordDone = 1'b1;
                end
            end
        end
        #1;
        in_valid = 1'b0;
        resync   = 1'b0;
        if (autoCheck) begin
            if (wordDone) begin
                checkOutput("word_valid", 16'(out_valid), 16'h1);
                popCheck("word_data");
            end else begin
                checkOutput("gap_valid", 16'(out_valid), 16'h0);
            end
        end
    endtask

    task automatic sendPlainBit(input logic p);
        logic raw;
        raw = p ^ txh[6] ^ txh[3];
        if (syncCnt == 0) begin
            wordBuf[wordPos] = p;
            if (wordPos == WIDTH - 1) sbQ.push_back(wordBuf);
        end
        applyStimulus(raw, 1'b0);
    endtask

    task automatic sendWord(input logic [7:0] w);
        for (int i = 0; i < WIDTH; i++) sendPlainBit(w[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in_bit   = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            if (autoCheck) checkOutput("idle_valid", 16'(out_valid), 16'h0);
        end
    endtask

    task automatic syncIn();
        for (int i = 0; i < 7; i++) begin
            sendPlainBit(1'($urandom_range(0, 1)));
            if (i == 5) checkOutput("sync_unlocked", 16'(locked), 16'h0);
            if (i == 6) checkOutput("sync_locked", 16'(locked), 16'h1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        in_bit    = 1'b0;
        in_valid  = 1'b0;
        resync    = 1'b0;
        out_ready = 1'b1;
        autoCheck = 1'b0;
        wordDone  = 1'b0;
        wordBuf   = 8'h00;

        // Reset state
        doReset();
        checkOutput("rst_data", 16'(out_data), 16'h0);
        checkOutput("rst_valid", 16'(out_valid), 16'h0);
        checkOutput("rst_locked", 16'(locked), 16'h0);
        checkOutput("rst_overrun", 16'(overrun), 16'h0);

        // Seven zeros then raw bits 1,0,0,0,1,0,0,1 decode to 0x01
        autoCheck = 1'b1;
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b0);
            if (i == 5) checkOutput("raw_unlocked", 16'(locked), 16'h0);
        end
        checkOutput("raw_locked", 16'(locked), 16'h1);
        rawPattern = 8'b1001_0001;
        sbQ.push_back(8'h01);
        for (int i = 0; i < WIDTH; i++) applyStimulus(rawPattern[i], 1'b0);
        idle(1);

        // Continuous ones decode to 0xFF words
        doReset();
        for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0);
        checkOutput("ones_locked", 16'(locked), 16'h1);
        for (int w = 0; w < 3; w++) begin
            sbQ.push_back(8'hFF);
            for (int i = 0; i < WIDTH; i++) applyStimulus(1'b1, 1'b0);
        end
        idle(1);

        // Stalled consumer: second word dropped, first held, overrun set
        doReset();
        autoCheck = 1'b0;
        out_ready = 1'b0;
        syncIn();
        sendWord(8'h5A);
        checkOutput("stall_valid1", 16'(out_valid), 16'h1);
        checkOutput("stall_ovr1", 16'(overrun), 16'h0);
        sendWord(8'hC3);
        void'(sbQ.pop_back());
        checkOutput("stall_valid2", 16'(out_valid), 16'h1);
        checkOutput("stall_ovr2", 16'(overrun), 16'h1);
        popCheck("stall_held");
        out_ready = 1'b1;
        idle(1);
        checkOutput("stall_drain", 16'(out_valid), 16'h0);
        checkOutput("stall_sticky", 16'(overrun), 16'h1);

        // Reset mid-word with a pending word and overrun set
        out_ready = 1'b0;
        sendWord(8'h66);
        checkOutput("mid_pending", 16'(out_valid), 16'h1);
        for (int i = 0; i < 3; i++) sendPlainBit(1'($urandom_range(0, 1)));
        doReset();
        checkOutput("mid_rst_data", 16'(out_data), 16'h0);
        checkOutput("mid_rst_valid", 16'(out_valid), 16'h0);
        checkOutput("mid_rst_locked", 16'(locked), 16'h0);
        checkOutput("mid_rst_overrun", 16'(overrun), 16'h0);

        // Word completion coinciding with a handshake
        out_ready = 1'b0;
        syncIn();
        sendWord(8'h9E);
        for (int i = 0; i < WIDTH - 1; i++) sendPlainBit(wordBuf[i] ^ 1'b1);
        out_ready = 1'b1;
        popCheck("hs_consumed");
        sendPlainBit(1'b1);
        checkOutput("hs_valid", 16'(out_valid), 16'h1);
        popCheck("hs_new_data");
        checkOutput("hs_overrun", 16'(overrun), 16'h0);
        idle(1);
        checkOutput("hs_drain", 16'(out_valid), 16'h0);

        // Resync after three bits, and resync on a completing bit
        doReset();
        autoCheck = 1'b1;
        syncIn();
        sendWord(8'h3C);
        for (int i = 0; i < 3; i++) sendPlainBit(1'($urandom_range(0, 1)));
        applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        checkOutput("rs_unlocked", 16'(locked), 16'h0);
        syncIn();
        sendWord(8'hA7);
        for (int i = 0; i < WIDTH - 1; i++) sendPlainBit(1'($urandom_range(0, 1)));
        applyStimulus(1'($urandom_range(0, 1)), 1'b1);
        checkOutput("rs_done_locked", 16'(locked), 16'h0);
        checkOutput("rs_done_overrun", 16'(overrun), 16'h0);
        syncIn();
        sendWord(8'h81);

        // Random in_valid gaps leave decoding untouched
        doReset();
        for (int i = 0; i < 7; i++) begin
            idle($urandom_range(0, 3));
            sendPlainBit(1'($urandom_range(0, 1)));
        end
        checkOutput("gap_locked", 16'(locked), 16'h1);
        for (int w = 0; w < 3; w++) begin
            logic [7:0] pw;
            pw = 8'($urandom_range(0, 255));
            for (int i = 0; i < WIDTH; i++) begin
                idle($urandom_range(0, 3));
                sendPlainBit(pw[i]);
            end
        end
        idle(2);
        checkOutput("sb_empty", 16'(sbQ.size()), 16'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/xor_descrambler_rx.md
XOR_DESCRAMBLER_RX -- requirements
Module: xor_descrambler_rx

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, output word width in bits (legal range 2..16).
REQ-002 SHALL provide port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL provide port in_bit  input  1  serial scrambled data bit.
REQ-005 SHALL provide port in_valid  input  1  in_bit is accepted on any clk edge where in_valid=1 (no backpressure).
REQ-006 SHALL provide port resync  input  1  single-cycle request to return to SYNC state.
REQ-007 SHALL provide port out_data  output  WIDTH  descrambled word, first received bit in bit 0.
REQ-008 SHALL provide port out_valid  output  1  out_data holds an unconsumed word.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts the word when out_valid=1 and out_ready=1.
REQ-010 SHALL provide port locked  output  1  high while in RUN state.
REQ-011 SHALL provide port overrun  output  1  sticky flag, a completed word was dropped.

Function
REQ-012 SHALL keep a 7-bit history register sr; every accepted bit shifts in: sr <= {sr[5:0], in_bit}.
REQ-013 SHALL compute descrambled bit d = in_bit XOR sr[6] XOR sr[3] (polynomial x^7+x^4+1, self-synchronizing), using sr before the shift.
REQ-014 SHALL implement a two-state FSM: SYNC and RUN.
REQ-015 In SYNC, accepted bits only update sr and a fill counter (0..6); no descrambled bit is produced.
REQ-016 SYNC -> RUN on the 7th accepted bit in SYNC; that bit is still discarded; locked goes high the following cycle.
REQ-017 In RUN, each accepted bit places d into the word assembler at position bit_cnt (LSB first) and increments bit_cnt.
REQ-018 When bit_cnt reaches WIDTH-1 and a bit is accepted, the assembled word is complete and bit_cnt wraps to 0.
REQ-019 A completed word SHALL load out_data and set out_valid on the next edge if out_valid=0, or if out_valid=1 and out_ready=1 in that same cycle.
REQ-020 If a word completes while out_valid=1 and out_ready=0, the new word SHALL be dropped, out_data SHALL be unchanged and overrun SHALL set.
REQ-021 out_valid SHALL clear after a handshake cycle unless a new word loads on the same edge.
REQ-022 Latency: out_valid rises on the edge that samples the last bit of a word (one register, zero extra cycles).
REQ-023 resync=1 SHALL force SYNC, clear fill counter, bit_cnt and the partial word; sr, out_data, out_valid, overrun are unaffected; in_bit sampled with resync=1 is ignored.
REQ-024 resync has priority over a word completing in the same cycle (word discarded, overrun unchanged).
REQ-025 overrun SHALL clear only on reset.
REQ-026 in_valid=0 cycles SHALL not alter sr, counters or partial word.

Reset
REQ-027 With rst_n=0 at a clk edge: state=SYNC, sr=0, fill counter=0, bit_cnt=0, partial word=0, out_data=0, out_valid=0, locked=0, overrun=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-word and mid-handshake, discarding any partial or pending word.

Verification
REQ-029 Reset then 7 bits of 0 then bits 1,0,0,0,1,0,0,1 (out_ready=1) -> locked=1 after 7th bit, out_data=0x01, out_valid=1 for exactly one cycle.
REQ-030 Reset then continuous 1s, out_ready=1 -> after sync, every 8 accepted bits out_data=0xFF with a one-cycle out_valid pulse.
REQ-031 Continuous 0s with out_ready=0 for two full words -> first word 0x00 held, out_valid stays 1, overrun=1 after second word completes.
REQ-032 Completion of a word coinciding with an out_ready=1 handshake -> out_valid remains 1, out_data updates, overrun stays 0.
REQ-033 resync pulse after 3 bits of a word -> locked=0 next cycle, next 7 bits discarded, following 8 bits form a clean word.
REQ-034 rst_n=0 asserted mid-word with out_valid=1 -> all outputs 0 on next edge; in_valid gaps of random length do not change any decoded value.
